byte_to_word_packer: RTL

BYTE_TO_WORD_PACKER -- requirements
Module: byte_to_word_packer

---
 rtl/byte_to_word_packer_pkg.sv | 22 ++
 rtl/word_fifo.sv | 56 +++++
 rtl/byte_to_word_packer.sv | 92 +++++++++
 3 files changed

// File: rtl/byte_to_word_packer_pkg.sv
// Shared widths and types for the byte-to-word packer and its output buffer.
// Optional flush-on-last behaviour is enabled by BYTE_TO_WORD_PACKER_FLUSH_EN.
package byte_to_word_packer_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTE_W         = 8;

  typedef logic [1:0] byte_cnt_t;

  typedef struct packed {
    logic [WORD_W-1:0]         data;
    logic [BYTES_PER_WORD-1:0] keep;
    logic                      last;
  } fifo_entry_t;

  // MSB-aligned lane mask covering lanes 0..idx inclusive.
  function automatic logic [BYTES_PER_WORD-1:0] keep_mask(input byte_cnt_t idx);
    return ~(4'b0111 >> idx);
  endfunction

endpackage

// File: rtl/word_fifo.sv
// Small in-order buffer of completed words between the packer and downstream.
// Head entry is presented directly from storage so it stays stable under backpressure.
module word_fifo
  import byte_to_word_packer_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  fifo_entry_t wdata,
  output logic        full,
  input  logic        pop,
  output logic        valid,
  output fifo_entry_t rdata
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  fifo_entry_t     mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q;
  logic            push_ok, pop_ok;

  assign full    = (cnt_q == CntW'(DEPTH));
  assign valid   = (cnt_q != '0);
  assign rdata   = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      if (push_ok && !pop_ok) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (!push_ok && pop_ok) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/byte_to_word_packer.sv
// Packs a byte stream MSB-first into 32-bit words and buffers them for downstream.
// Define BYTE_TO_WORD_PACKER_FLUSH_EN to let in_last terminate a partial word.
module byte_to_word_packer
  import byte_to_word_packer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BYTE_W-1:0]         in_data,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WORD_W-1:0]         out_data,
  output logic [BYTES_PER_WORD-1:0] out_keep,
  output logic                      out_last,
  output logic [15:0]               word_count
);

  byte_cnt_t         cnt_q;
  logic [WORD_W-1:0] acc_q;
  logic [15:0]       word_count_q;
  logic [WORD_W-1:0] word_d;
  logic              fifo_full, accept, push, pop;
  fifo_entry_t       push_entry, head;

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  // Byte lane 0 lands in the top byte of the word.
  assign word_d = acc_q |
                  (WORD_W'(in_data) << (BYTE_W * (BYTES_PER_WORD - 1 - int'(cnt_q))));

`ifdef BYTE_TO_WORD_PACKER_FLUSH_EN
  // A last byte pushes regardless of lane, so it also needs buffer space.
  assign in_ready        = !fifo_full || ((cnt_q != 2'd3) && !in_last);
  assign push            = accept && ((cnt_q == 2'd3) || in_last);
  assign push_entry.keep = keep_mask(cnt_q);
  assign push_entry.last = in_last;
`else
  logic unused_in_last;
  assign unused_in_last  = in_last;
  assign in_ready        = !fifo_full || (cnt_q != 2'd3);
  assign push            = accept && (cnt_q == 2'd3);
  assign push_entry.keep = '1;
  assign push_entry.last = 1'b0;
`endif

  assign push_entry.data = word_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      acc_q        <= '0;
      word_count_q <= '0;
    end else begin
      if (accept) begin
        if (push) begin
          cnt_q <= '0;
          acc_q <= '0;
        end else begin
          cnt_q <= cnt_q + 2'd1;
          acc_q <= word_d;
        end
      end
      if (pop) begin
        word_count_q <= word_count_q + 16'd1;
      end
    end
  end

  word_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_word_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (push_entry),
    .full  (fifo_full),
    .pop   (pop),
    .valid (out_valid),
    .rdata (head)
  );

  assign out_data   = head.data;
  assign out_keep   = head.keep;
  assign out_last   = head.last;
  assign word_count = word_count_q;

endmodule
